mem_port_arbiter: RTL and testbench

- Shares the single-port unified MEM between two requesters:
  - master 0: the multi-cycle CPU core, for fetch and load/store;
  - master 1: the program loader / debug port.
- Sequences each access as grant, then a fixed-latency memory phase, then a response.
- Sits between the requesters and MEM. It owns mem_addr, MemWrite and mem_write_data.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port, fixed-latency memory: grant, hold for RD_LAT, respond.
// Define ARB_ROUND_ROBIN_EN to alternate masters under contention instead of fixed m0 priority.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          busy_o
);

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic          win_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    gnt_q;
    logic [1:0]    rvalid_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic          busy_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_q;
`endif

    logic          any_req_s;
    logic          sel_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          to_resp_s;

    assign any_req_s = m0_req_i | m1_req_i;

    // Winner selection: a lone requester always wins; contention resolved by policy.
    always_comb begin
        sel_s = 1'b0;
        if (m0_req_i && m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel_s = ~last_q;
`else
            sel_s = 1'b0;
`endif
        end else if (m1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Request mux feeding the latch taken on the IDLE->GRANT edge.
    always_comb begin
        if (sel_s) begin
            sel_we_s    = m1_we_i;
            sel_addr_s  = m1_addr_i;
            sel_wdata_s = m1_wdata_i;
        end else begin
            sel_we_s    = m0_we_i;
            sel_addr_s  = m0_addr_i;
            sel_wdata_s = m0_wdata_i;
        end
    end

    // Marks the edge on which the memory phase ends and read data is valid.
    always_comb begin
        to_resp_s = 1'b0;
        case (state_q)
            ST_GRANT:  to_resp_s = (RD_LAT == 1);
            ST_ACCESS: to_resp_s = (cnt_q == CNT_ONE);
            default:   to_resp_s = 1'b0;
        endcase
    end

    // Access sequencer; every output is a register so reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            rvalid_q <= 2'b00;
            if (to_resp_s) begin
                rvalid_q <= win_q ? 2'b10 : 2'b01;
                // Writes are acknowledged but leave the read-data holding register untouched.
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_q <= mem_rdata_i;
                    end else begin
                        rdata0_q <= mem_rdata_i;
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_q     <= ST_GRANT;
                        win_q       <= sel_s;
                        we_q        <= sel_we_s;
                        mem_addr_q  <= sel_addr_s;
                        mem_wdata_q <= sel_wdata_s;
                        mem_we_q    <= sel_we_s;
                        gnt_q       <= sel_s ? 2'b10 : 2'b01;
                        busy_q      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    gnt_q    <= 2'b00;
                    mem_we_q <= 1'b0;
                    cnt_q    <= CNT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
                    last_q   <= win_q;
`endif
                    state_q  <= (RD_LAT == 1) ? ST_RESP : ST_ACCESS;
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q    <= 2'b00;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt_o    = gnt_q[0];
    assign m1_gnt_o    = gnt_q[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3, each with a
// memory model that only returns valid data once the address has been held RD_LAT cycles.
module tb_mem_port_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        load_mem;
    logic [1:0]  m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr [2];
    logic [31:0] m0_wdata[2];
    logic [31:0] m1_addr [2];
    logic [31:0] m1_wdata[2];
    logic [1:0]  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, busy;
    logic [31:0] m0_rdata [2];
    logic [31:0] m1_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    logic [31:0] mem [2][64];
    logic [31:0] prev_addr[2];
    int          hold_cnt [2];
    int          held_s   [2];

    exp_t        sb0_q[$];
    exp_t        sb1_q[$];
    logic [31:0] last_rd [2][2];
    logic        active [2];
    logic [31:0] held_addr [2];
    int          since_gnt [2];
    vec_t        vecs [8];

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT0)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[0]), .m0_we_i(m0_we[0]), .m0_addr_i(m0_addr[0]), .m0_wdata_i(m0_wdata[0]),
        .m0_gnt_o(m0_gnt[0]), .m0_rvalid_o(m0_rvalid[0]), .m0_rdata_o(m0_rdata[0]),
        .m1_req_i(m1_req[0]), .m1_we_i(m1_we[0]), .m1_addr_i(m1_addr[0]), .m1_wdata_i(m1_wdata[0]),
        .m1_gnt_o(m1_gnt[0]), .m1_rvalid_o(m1_rvalid[0]), .m1_rdata_o(m1_rdata[0]),
        .mem_addr_o(mem_addr[0]), .mem_we_o(mem_we[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT1)) u_dut_lat3 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[1]), .m0_we_i(m0_we[1]), .m0_addr_i(m0_addr[1]), .m0_wdata_i(m0_wdata[1]),
        .m0_gnt_o(m0_gnt[1]), .m0_rvalid_o(m0_rvalid[1]), .m0_rdata_o(m0_rdata[1]),
        .m1_req_i(m1_req[1]), .m1_we_i(m1_we[1]), .m1_addr_i(m1_addr[1]), .m1_wdata_i(m1_wdata[1]),
        .m1_gnt_o(m1_gnt[1]), .m1_rvalid_o(m1_rvalid[1]), .m1_rdata_o(m1_rdata[1]),
        .mem_addr_o(mem_addr[1]), .mem_we_o(mem_we[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: word-indexed by addr[7:2]; data is garbage until the address has been stable long enough.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            held_s[d]    = (mem_addr[d] == prev_addr[d]) ? hold_cnt[d] + 1 : 1;
            mem_rdata[d] = (held_s[d] >= ((d == 0) ? LAT0 : LAT1)) ? mem[d][mem_addr[d][7:2]] : 32'hBAD0_BAD0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (load_mem) begin
                for (int i = 0; i < 64; i++) mem[d][i] <= 32'h0;
                mem[d][2] <= 32'h0000_00A5;
                mem[d][3] <= 32'h0C0C_0C0C;
                mem[d][4] <= 32'hDEAD_BEEF;
            end else if (mem_we[d]) begin
                mem[d][mem_addr[d][7:2]] <= mem_wdata[d];
            end
            prev_addr[d] <= mem_addr[d];
            hold_cnt[d]  <= held_s[d];
        end
    end

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0_q.size() : sb1_q.size();
    endfunction

    task automatic sb_push(input int d, input exp_t e);
        if (d == 0) sb0_q.push_back(e);
        else        sb1_q.push_back(e);
    endtask

    task automatic sb_pop(input int d, output exp_t e);
        if (d == 0) e = sb0_q.pop_front();
        else        e = sb1_q.pop_front();
    endtask

    task automatic drive(input int d, input int m, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] w);
        if (m == 0) begin
            m0_req[d] = r; m0_we[d] = we; m0_addr[d] = a; m0_wdata[d] = w;
        end else begin
            m1_req[d] = r; m1_we[d] = we; m1_addr[d] = a; m1_wdata[d] = w;
        end
    endtask

    // Per-cycle protocol monitor and scoreboard consumer for one instance.
    task automatic monitor_dut(input int d);
        logic        g0, g1, r0, r1;
        logic [31:0] rd;
        exp_t        e;
        g0 = m0_gnt[d]; g1 = m1_gnt[d]; r0 = m0_rvalid[d]; r1 = m1_rvalid[d];
        check("busy", d, 32'(busy[d]), 32'(active[d] | g0 | g1));
        if (g0 | g1) check("single_gnt", d, 32'(g0 & g1), 32'd0);
        if (r0 | r1) check("single_rvalid", d, 32'(r0 & r1), 32'd0);
        if (!(g0 | g1)) begin
            check("mem_we_outside_grant", d, 32'(mem_we[d]), 32'd0);
            check("mem_addr_hold", d, mem_addr[d], held_addr[d]);
        end
        if (g0 | g1) begin
            active[d]    = 1'b1;
            held_addr[d] = mem_addr[d];
            since_gnt[d] = 0;
        end else begin
            since_gnt[d]++;
        end
        if (r0 | r1) begin
            rd = r1 ? m1_rdata[d] : m0_rdata[d];
            check("rvalid_expected", d, 32'(sb_size(d) > 0), 32'd1);
            if (sb_size(d) > 0) begin
                sb_pop(d, e);
                check("resp_master", d, 32'(r1 ? 1 : 0), 32'(e.m));
                check("resp_data", d, rd, e.data);
                check("latency", d, 32'(since_gnt[d]), 32'((d == 0) ? LAT0 : LAT1));
            end
            active[d] = 1'b0;
        end
    endtask

    initial begin
        active[0] = 1'b0; active[1] = 1'b0;
        held_addr[0] = 32'd0; held_addr[1] = 32'd0;
        since_gnt[0] = 0; since_gnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    active[d] = 1'b0; held_addr[d] = 32'd0; since_gnt[d] = 0;
                end else begin
                    monitor_dut(d);
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        tick();
        while ((busy[d] || sb_size(d) != 0) && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", d, 32'(n < 40), 32'd1);
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_gnt"},    d, 32'({m0_gnt[d], m1_gnt[d]}), 32'd0);
        check({tag, "_rvalid"}, d, 32'({m0_rvalid[d], m1_rvalid[d]}), 32'd0);
        check({tag, "_mem_we"}, d, 32'(mem_we[d]), 32'd0);
        check({tag, "_busy"},   d, 32'(busy[d]), 32'd0);
        check({tag, "_addr"},   d, mem_addr[d], 32'd0);
        check({tag, "_wdata"},  d, mem_wdata[d], 32'd0);
        check({tag, "_rdata0"}, d, m0_rdata[d], 32'd0);
        check({tag, "_rdata1"}, d, m1_rdata[d], 32'd0);
    endtask

    // One isolated access; called with the instance idle, returns with it idle again.
    task automatic access(input int d, input int m, input logic we, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] x);
        exp_t e;
        drive(d, m, 1'b1, we, a, w);
        e.m = m; e.we = we;
        if (we) begin
            e.data = last_rd[d][m];
        end else begin
            e.data = x;
            last_rd[d][m] = x;
        end
        sb_push(d, e);
        tick();
        check("gnt", d, 32'((m == 0) ? m0_gnt[d] : m1_gnt[d]), 32'd1);
        check("gnt_other", d, 32'((m == 0) ? m1_gnt[d] : m0_gnt[d]), 32'd0);
        check("gnt_mem_addr", d, mem_addr[d], a);
        check("gnt_mem_we", d, 32'(mem_we[d]), 32'(we));
        if (we) check("gnt_mem_wdata", d, mem_wdata[d], w);
        drive(d, m, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_idle(d);
        check("m0_rdata_held", d, m0_rdata[d], last_rd[d][0]);
        check("m1_rdata_held", d, m1_rdata[d], last_rd[d][1]);
    endtask

    // Both masters request continuously for four grants.
    task automatic hold_both(input int d);
        int   order[4];
        int   n;
        exp_t e;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            e.m = order[k]; e.we = 1'b0;
            e.data = (order[k] == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            last_rd[d][order[k]] = e.data;
            sb_push(d, e);
        end
        drive(d, 0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        drive(d, 1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            tick();
            while (!(m0_gnt[d] | m1_gnt[d]) && n < 20) begin
                tick();
                n++;
            end
            check("arb_wait", d, 32'(n < 20), 32'd1);
            check("arb_order", d, 32'(m1_gnt[d] ? 1 : 0), 32'(order[k]));
            if (k == 3) begin
                drive(d, 0, 1'b0, 1'b0, 32'd0, 32'd0);
                drive(d, 1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        wait_idle(d);
    endtask

    initial begin
        rst = 1'b1;
        load_mem = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1'b0, 1'b0, 32'd0, 32'd0);
            drive(d, 1, 1'b0, 1'b0, 32'd0, 32'd0);
            last_rd[d][0] = 32'd0;
            last_rd[d][1] = 32'd0;
        end
        vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0};
        vecs[4] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_F00D};
        vecs[5] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_00A5};
        vecs[6] = '{0, 1'b0, 32'h0000_000C, 32'h0,         32'h0C0C_0C0C};
        vecs[7] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};

        @(posedge clk);
        #1;
        load_mem = 1'b0;
        tick();
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                access(d, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rexp);
            end
            hold_both(d);
        end

        // Reset in the middle of an RD_LAT=3 m1 write: nothing may complete.
        drive(1, 1, 1'b1, 1'b1, 32'h0000_0048, 32'h5555_AAAA);
        tick();
        check("abort_gnt", 1, 32'(m1_gnt[1]), 32'd1);
        drive(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("abort_in_access", 1, 32'(busy[1]), 32'd1);
        rst = 1'b1;
        #1;
        check_zero(1, "rst_mid");
        for (int d = 0; d < 2; d++) begin
            last_rd[d][0] = 32'd0;
            last_rd[d][1] = 32'd0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_rvalid_after_abort", 1, 32'(m1_rvalid[1]), 32'd0);
        end
        access(1, 0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF);
        access(0, 0, 1'b0, 32'h0000_000C, 32'd0, 32'h0C0C_0C0C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
